// File: rtl/byte_collector_pkg.sv
// Shared definitions for the byte collector.
// Holds the collector FSM state encoding and the default word width
// and output buffer depth used by byte_collector and its bench.
package byte_collector_pkg;

   localparam int unsigned DefaultWidth = 8;
   localparam int unsigned DefaultDepth = 2;

   // StIdle: no partial word held, bit counter at 0.
   // StCollect: at least one bit of the current word has been accepted.
   typedef enum logic [0:0] {
      StIdle    = 1'b0,
      StCollect = 1'b1
   } state_e;

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO holding completed words.
// Ports:
//   clk, rst    - clock and synchronous active-high reset
//   clear       - synchronous empty of the buffer (pointers only)
//   push, data  - write request and word; ignored when full without a pop
//   pop         - read request; ignored when empty
//   full, empty - occupancy status
//   head        - oldest entry, forced to 0 while empty
module sync_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   input  logic             push,
   input  logic [WIDTH-1:0] data,
   input  logic             pop,
   output logic             full,
   output logic             empty,
   output logic [WIDTH-1:0] head
);

   localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CntW = $clog2(DEPTH + 1);
   localparam logic [PtrW-1:0] LastPtr = PtrW'(DEPTH - 1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CntW-1:0]  count_q, count_d;
   logic             do_push, do_pop;

   assign full  = (count_q == CntW'(DEPTH));
   assign empty = (count_q == '0);
   assign head  = empty ? '0 : mem_q[rd_ptr_q];

   // A pop in the same cycle frees the slot, so a push to a full buffer still lands.
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) begin
         wr_ptr_d = (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + PtrW'(1);
      end
      if (do_pop) begin
         rd_ptr_d = (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + PtrW'(1);
      end
      unique case ({do_push, do_pop})
         2'b10:   count_d = count_q + CntW'(1);
         2'b01:   count_d = count_q - CntW'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset: head is masked while empty.
   always_ff @(posedge clk) begin
      if (do_push && !rst && !clear) begin
         mem_q[wr_ptr_q] <= data;
      end
   end

endmodule

// File: rtl/byte_collector.sv
// Serial-to-parallel word collector with a small output buffer.
// Bits arrive LSB first, qualified by bit_valid; each completed word is
// pushed into a DEPTH-entry FIFO whose head is presented on word_out.
// Ports:
//   clk, rst              - clock and synchronous active-high reset
//   bit_in, bit_valid     - serial data and its qualifier
//   flush                 - clears partial word and buffer
//   word_out, word_valid  - buffer head and non-empty flag
//   word_ready            - consumer accept; pops when word_valid is high
//   overflow              - sticky, set when a completed word is dropped
//   word_count            - successful pushes, modulo 256
module byte_collector
   import byte_collector_pkg::*;
#(
   parameter int unsigned WIDTH = DefaultWidth,
   parameter int unsigned DEPTH = DefaultDepth
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             bit_in,
   input  logic             bit_valid,
   input  logic             flush,
   output logic [WIDTH-1:0] word_out,
   output logic             word_valid,
   input  logic             word_ready,
   output logic             overflow,
   output logic [7:0]       word_count
);

   localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CntW-1:0] LastBit = CntW'(WIDTH - 1);

   state_e           state_q, state_d;
   logic [CntW-1:0]  bit_cnt_q, bit_cnt_d, bit_idx;
   logic [WIDTH-1:0] shift_q, shift_d, done_word;
   logic             word_done;
   logic             push, pop, full, empty, push_ok;
   logic             overflow_q;
   logic [7:0]       count_q;

   // In StIdle the counter is 0 by construction; selecting on state keeps the
   // first bit of every word anchored at the LSB.
   assign bit_idx = (state_q == StIdle) ? '0 : bit_cnt_q;

   always_comb begin
      state_d   = state_q;
      bit_cnt_d = bit_cnt_q;
      shift_d   = shift_q;
      word_done = 1'b0;
      done_word = shift_q;
      if (bit_valid) begin
         done_word[bit_idx] = bit_in;
         if (bit_idx == LastBit) begin
            word_done = 1'b1;
            bit_cnt_d = '0;
            shift_d   = '0;
            state_d   = StIdle;
         end else begin
            bit_cnt_d = bit_idx + CntW'(1);
            shift_d   = done_word;
            state_d   = StCollect;
         end
      end
      if (flush) begin
         state_d   = StIdle;
         bit_cnt_d = '0;
         shift_d   = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= StIdle;
         bit_cnt_q <= '0;
         shift_q   <= '0;
      end else begin
         state_q   <= state_d;
         bit_cnt_q <= bit_cnt_d;
         shift_q   <= shift_d;
      end
   end

   // flush outranks both the completing bit and the consumer pop.
   assign push    = word_done && !flush;
   assign pop     = !empty && word_ready && !flush;
   assign push_ok = push && (!full || pop);

   sync_fifo #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .clear (flush),
      .push  (push),
      .data  (done_word),
      .pop   (pop),
      .full  (full),
      .empty (empty),
      .head  (word_out)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         overflow_q <= 1'b0;
         count_q    <= '0;
      end else begin
         if (push && !push_ok) begin
            overflow_q <= 1'b1;
         end
         if (push_ok) begin
            count_q <= count_q + 8'd1;
         end
      end
   end

   assign word_valid = !empty;
   assign overflow   = overflow_q;
   assign word_count = count_q;

endmodule

// File: tb/tb_byte_collector.sv
// Randomised and directed bench for byte_collector against a queue-based model.
module tb_byte_collector;

   localparam int unsigned W = 8;
   localparam int unsigned D = 2;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         bit_in = 1'b0;
   logic         bit_valid = 1'b0;
   logic         flush = 1'b0;
   logic         word_ready = 1'b0;
   logic [W-1:0] word_out;
   logic         word_valid;
   logic         overflow;
   logic [7:0]   word_count;

   int checks = 0;
   int failures = 0;

   // Reference model state
   logic [W-1:0] m_q[$];
   logic [W-1:0] m_part;
   int           m_n;
   logic         m_ovf;
   int           m_cnt;

   always #5 clk = ~clk;

   byte_collector #(
      .WIDTH (W),
      .DEPTH (D)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .bit_in     (bit_in),
      .bit_valid  (bit_valid),
      .flush      (flush),
      .word_out   (word_out),
      .word_valid (word_valid),
      .word_ready (word_ready),
      .overflow   (overflow),
      .word_count (word_count)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_step(input logic v, input logic b, input logic rdy, input logic fl,
                             input logic rs);
      logic         do_pop, was_full, done;
      logic [W-1:0] w;
      done = 1'b0;
      w = '0;
      if (rs) begin
         m_q.delete();
         m_part = '0;
         m_n = 0;
         m_ovf = 1'b0;
         m_cnt = 0;
      end else if (fl) begin
         m_q.delete();
         m_part = '0;
         m_n = 0;
      end else begin
         do_pop = (m_q.size() > 0) && rdy;
         was_full = (m_q.size() == D);
         if (v) begin
            m_part = m_part | (W'(b) << m_n);
            m_n++;
            if (m_n == W) begin
               done = 1'b1;
               w = m_part;
               m_part = '0;
               m_n = 0;
            end
         end
         if (do_pop) void'(m_q.pop_front());
         if (done) begin
            if (!was_full || do_pop) begin
               m_q.push_back(w);
               m_cnt = (m_cnt + 1) % 256;
            end else begin
               m_ovf = 1'b1;
            end
         end
      end
   endtask

   // Drive one cycle of inputs, advance the model with the edge, compare after it.
   task automatic cycle(input logic v, input logic b, input logic rdy, input logic fl,
                        input logic rs);
      bit_valid = v;
      bit_in = b;
      word_ready = rdy;
      flush = fl;
      rst = rs;
      @(posedge clk);
      model_step(v, b, rdy, fl, rs);
      #1;
      check_eq("word_valid", 32'(word_valid), 32'(m_q.size() > 0));
      check_eq("word_out", 32'(word_out), (m_q.size() > 0) ? 32'(m_q[0]) : 32'd0);
      check_eq("overflow", 32'(overflow), 32'(m_ovf));
      check_eq("word_count", 32'(word_count), 32'(m_cnt));
   endtask

   // Send a word LSB first; optional idle gap before each bit; ready on the last bit separate.
   task automatic send_word(input logic [W-1:0] w, input logic gap, input logic rdy,
                            input logic rdy_last);
      for (int i = 0; i < W; i++) begin
         if (gap) cycle(1'b0, 1'b0, rdy, 1'b0, 1'b0);
         cycle(1'b1, w[i], (i == W - 1) ? rdy_last : rdy, 1'b0, 1'b0);
      end
   endtask

   initial begin
      logic [7:0] saved_cnt;
      logic [W-1:0] rw;
      m_q.delete();
      m_part = '0;
      m_n = 0;
      m_ovf = 1'b0;
      m_cnt = 0;

      cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      check_eq("reset_out", 32'({word_valid, word_out, overflow, word_count}), 32'd0);

      // 0xA5 continuous, ready high: visible for one cycle after bit 8
      send_word(8'hA5, 1'b0, 1'b1, 1'b1);
      check_eq("a5_word", 32'(word_out), 32'hA5);
      check_eq("a5_valid", 32'(word_valid), 32'd1);
      check_eq("a5_count", 32'(word_count), 32'd1);
      cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      check_eq("a5_gone", 32'(word_valid), 32'd0);

      // 0x3C with gapped bit_valid
      send_word(8'h3C, 1'b1, 1'b0, 1'b0);
      check_eq("3c_word", 32'(word_out), 32'h3C);
      cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

      // Overflow: three words into a two-entry buffer
      cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      send_word(8'h11, 1'b0, 1'b0, 1'b0);
      send_word(8'h22, 1'b0, 1'b0, 1'b0);
      send_word(8'h33, 1'b0, 1'b0, 1'b0);
      check_eq("ovf_set", 32'(overflow), 32'd1);
      check_eq("ovf_count", 32'(word_count), 32'd2);
      check_eq("ovf_head", 32'(word_out), 32'h11);
      cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      check_eq("ovf_pop2", 32'(word_out), 32'h22);
      cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      check_eq("ovf_empty", 32'(word_valid), 32'd0);

      // Full buffer, word completes in the same cycle as a pop
      cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      send_word(8'h55, 1'b0, 1'b0, 1'b0);
      send_word(8'h66, 1'b0, 1'b0, 1'b0);
      send_word(8'h44, 1'b0, 1'b0, 1'b1);
      check_eq("simul_noovf", 32'(overflow), 32'd0);
      check_eq("simul_head", 32'(word_out), 32'h66);
      cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      check_eq("simul_tail", 32'(word_out), 32'h44);

      // Flush after 3 bits, then 0x5A
      saved_cnt = word_count;
      for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      cycle(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
      check_eq("flush_cnt", 32'(word_count), 32'(saved_cnt));
      check_eq("flush_empty", 32'(word_valid), 32'd0);
      send_word(8'h5A, 1'b0, 1'b0, 1'b0);
      check_eq("flush_word", 32'(word_out), 32'h5A);
      check_eq("flush_cnt2", 32'(word_count), 32'(saved_cnt + 8'd1));

      // Reset mid-word, then 0xFF
      for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      cycle(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
      check_eq("rst_outs", 32'({word_valid, word_out, overflow, word_count}), 32'd0);
      send_word(8'hFF, 1'b0, 1'b0, 1'b0);
      check_eq("rst_ff", 32'(word_out), 32'hFF);
      cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

      // 256 pushes wrap word_count
      saved_cnt = word_count;
      for (int k = 0; k < 256; k++) begin
         rw = W'($urandom);
         send_word(rw, 1'b0, 1'b1, 1'b1);
      end
      check_eq("cnt_wrap", 32'(word_count), 32'(saved_cnt));

      // Random traffic
      for (int k = 0; k < 4000; k++) begin
         cycle(1'($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom_range(0, 2) == 0),
               1'($urandom_range(0, 60) == 0), 1'($urandom_range(0, 400) == 0));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
